// File: rtl/spike_weight_accumulator.sv
// Synaptic front-end: sums FP32 weights of spikes received during a timestep
// and hands the total to the potential adder over valid/ready.

module Addition_Subtraction (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic        Exception,
  output logic [31:0] result
);
  logic [31:0] b_eff, x, y;
  logic [7:0]  ex, ey, diff;
  logic [23:0] mx, my, my_sh, dif, norm;
  logic [24:0] sum;
  logic [4:0]  lz;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (v[i]) n = 5'(23 - i);
    end
    return n;
  endfunction

  // Magnitude-ordered operands; truncating alignment, subnormal results flush to zero
  always_comb begin
    b_eff = {b_operand[31] ^ AddBar_Sub, b_operand[30:0]};
    if (a_operand[30:0] >= b_eff[30:0]) begin
      x = a_operand;
      y = b_eff;
    end else begin
      x = b_eff;
      y = a_operand;
    end
    ex    = x[30:23];
    ey    = y[30:23];
    mx    = {|ex, x[22:0]};
    my    = {|ey, y[22:0]};
    diff  = ex - ey;
    my_sh = (diff > 8'd23) ? 24'd0 : (my >> diff);
    sum   = {1'b0, mx} + {1'b0, my_sh};
    dif   = mx - my_sh;
    lz    = lzc24(dif);
    norm  = dif << lz;
    Exception = 1'b0;
    result    = 32'h0000_0000;
    if ((&a_operand[30:23]) || (&b_operand[30:23])) begin
      Exception = 1'b1;
      result    = 32'h7FC0_0000;
    end else if (a_operand[30:0] == 31'd0) begin
      result = b_eff;
    end else if (b_operand[30:0] == 31'd0) begin
      result = a_operand;
    end else if (x[31] == y[31]) begin
      if (sum[24]) begin
        if (ex == 8'd254) begin
          Exception = 1'b1;
          result    = {x[31], 8'hFF, 23'd0};
        end else begin
          result = {x[31], ex + 8'd1, sum[23:1]};
        end
      end else begin
        result = {x[31], ex, sum[22:0]};
      end
    end else if (dif != 24'd0 && {3'b000, lz} < ex) begin
      result = {x[31], ex - 8'(lz), norm[22:0]};
    end
  end
endmodule

module spike_weight_accumulator #(
  parameter int unsigned N_SRC = 10,
  parameter int unsigned SRC_W = 4
) (
  input  logic             CLK_Accum,
  input  logic             RST_N_Accum,
  input  logic             wr_en,
  input  logic [SRC_W-1:0] wr_addr,
  input  logic [31:0]      wr_data,
  input  logic             ts_start,
  input  logic             ts_end,
  input  logic             spike_valid,
  input  logic [SRC_W-1:0] spike_src,
  output logic             spike_ready,
  output logic [31:0]      input_weight,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       spike_count,
  output logic             drop_flag,
  output logic             exc_flag
);
  typedef enum logic [1:0] {IDLE, ACCUM, ADD, OUT} state_t;

  state_t      state_q, state_n;
  logic [31:0] weights [N_SRC];
  logic [31:0] acc_q, acc_n, w_reg_q, w_reg_n, add_res;
  logic        skip_q, skip_n, endp_q, endp_n, add_exc;
  logic [7:0]  cnt_n;
  logic        drop_n, exc_n, ready_n, valid_n;
  logic        src_ok_c, accept_c;

  Addition_Subtraction u_add (
    .a_operand (acc_q),
    .b_operand (w_reg_q),
    .AddBar_Sub(1'b0),
    .Exception (add_exc),
    .result    (add_res)
  );

  assign input_weight = acc_q;
  assign src_ok_c     = 32'(spike_src) < N_SRC;
  assign accept_c     = (state_q == ACCUM) && spike_ready && spike_valid;

  // Next-state and datapath updates
  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    w_reg_n = w_reg_q;
    skip_n  = skip_q;
    endp_n  = endp_q;
    cnt_n   = spike_count;
    drop_n  = drop_flag;
    exc_n   = exc_flag;
    case (state_q)
      IDLE: begin
        if (ts_start) begin
          state_n = ACCUM;
          acc_n   = 32'h0000_0000;
          cnt_n   = 8'd0;
          drop_n  = 1'b0;
          exc_n   = 1'b0;
          endp_n  = 1'b0;
        end
      end
      ACCUM: begin
        if (endp_q) begin
          state_n = OUT;
          endp_n  = 1'b0;
        end else if (accept_c) begin
          state_n = ADD;
          endp_n  = ts_end;
          skip_n  = !src_ok_c;
          if (src_ok_c) begin
            w_reg_n = weights[spike_src];
            if (spike_count != 8'hFF) cnt_n = spike_count + 8'd1;
          end else begin
            drop_n = 1'b1;
          end
        end else if (ts_end) begin
          state_n = OUT;
        end
      end
      ADD: begin
        if (!skip_q) begin
          acc_n = add_res;
          exc_n = exc_flag | add_exc;
        end
        if (endp_q) begin
          state_n = OUT;
          endp_n  = 1'b0;
        end else begin
          state_n = ACCUM;
          endp_n  = ts_end;
        end
      end
      OUT: begin
        if (out_valid && out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n == ACCUM) && !endp_n;
    valid_n = (state_n == OUT);
  end

  always_ff @(posedge CLK_Accum or negedge RST_N_Accum) begin
    if (!RST_N_Accum) begin
      state_q     <= IDLE;
      acc_q       <= 32'h0000_0000;
      w_reg_q     <= 32'h0000_0000;
      skip_q      <= 1'b0;
      endp_q      <= 1'b0;
      spike_count <= 8'd0;
      drop_flag   <= 1'b0;
      exc_flag    <= 1'b0;
      spike_ready <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      state_q     <= state_n;
      acc_q       <= acc_n;
      w_reg_q     <= w_reg_n;
      skip_q      <= skip_n;
      endp_q      <= endp_n;
      spike_count <= cnt_n;
      drop_flag   <= drop_n;
      exc_flag    <= exc_n;
      spike_ready <= ready_n;
      out_valid   <= valid_n;
    end
  end

  // Weight file; a same-cycle lookup sees the pre-write value
  always_ff @(posedge CLK_Accum or negedge RST_N_Accum) begin
    if (!RST_N_Accum) begin
      for (int i = 0; i < N_SRC; i++) weights[i] <= 32'h0000_0000;
    end else if (wr_en && (32'(wr_addr) < N_SRC)) begin
      weights[wr_addr] <= wr_data;
    end
  end
endmodule

// File: tb/tb_spike_weight_accumulator.sv
// Scoreboard bench for spike_weight_accumulator: expected sums are queued at
// ts_end and compared when the output handshake completes.

module tb_spike_weight_accumulator;
  logic        CLK_Accum = 1'b0;
  logic        RST_N_Accum;
  logic        wr_en, ts_start, ts_end, spike_valid, out_ready;
  logic [3:0]  wr_addr, spike_src;
  logic [31:0] wr_data;
  logic        spike_ready, out_valid, drop_flag, exc_flag;
  logic [31:0] input_weight;
  logic [7:0]  spike_count;

  typedef struct packed {
    logic [31:0] w;
    logic [7:0]  cnt;
    logic        drop;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  spike_weight_accumulator #(.N_SRC(10), .SRC_W(4)) dut (
    .CLK_Accum   (CLK_Accum),
    .RST_N_Accum (RST_N_Accum),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .ts_start    (ts_start),
    .ts_end      (ts_end),
    .spike_valid (spike_valid),
    .spike_src   (spike_src),
    .spike_ready (spike_ready),
    .input_weight(input_weight),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .spike_count (spike_count),
    .drop_flag   (drop_flag),
    .exc_flag    (exc_flag)
  );

  always #5 CLK_Accum = ~CLK_Accum;

  task automatic tick();
    @(posedge CLK_Accum);
    #1;
  endtask

  task automatic write_w(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_ts();
    ts_start = 1'b1;
    tick();
    ts_start = 1'b0;
  endtask

  task automatic send_spike(input logic [3:0] s);
    int n = 0;
    while (!spike_ready && n < 20) begin tick(); n++; end
    if (!spike_ready) begin
      checks++; failures++;
      $display("FAIL spike_ready_timeout got=%b want=1", spike_ready);
    end
    spike_valid = 1'b1; spike_src = s;
    tick();
    spike_valid = 1'b0;
  endtask

  // Closes the timestep, waits (bounded) for out_valid, captures, handshakes
  task automatic finish_ts(output exp_t got, output bit ok);
    int n = 0;
    ts_end = 1'b1;
    tick();
    ts_end = 1'b0;
    while (!out_valid && n < 20) begin tick(); n++; end
    ok  = out_valid;
    got = '{w: input_weight, cnt: spike_count, drop: drop_flag};
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({out_valid, spike_ready, input_weight, spike_count, drop_flag, exc_flag} !== 44'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0",
               {out_valid, spike_ready, input_weight, spike_count, drop_flag, exc_flag});
    end
  endtask

  task automatic test_sum();
    exp_t got, e; bit ok;
    write_w(4'd0, 32'h3F80_0000);
    write_w(4'd1, 32'h4000_0000);
    start_ts();
    send_spike(4'd0); send_spike(4'd1); send_spike(4'd1);
    exp_q.push_back('{w: 32'h40A0_0000, cnt: 8'd3, drop: 1'b0});
    finish_ts(got, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin failures++; $display("FAIL sum_timeout got=%b want=1", ok); end
    checks++;
    if (got !== e) begin failures++; $display("FAIL sum_result got=%h want=%h", got, e); end
    checks++;
    if (exc_flag !== 1'b0) begin failures++; $display("FAIL sum_exc got=%b want=0", exc_flag); end
  endtask

  task automatic test_empty_hold();
    exp_t got, e;
    logic [31:0] w0;
    start_ts();
    exp_q.push_back('{w: 32'h0000_0000, cnt: 8'd0, drop: 1'b0});
    ts_end = 1'b1;
    tick();
    ts_end = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL empty_latency got=%b want=1", out_valid); end
    got = '{w: input_weight, cnt: spike_count, drop: drop_flag};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL empty_result got=%h want=%h", got, e); end
    w0 = input_weight;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || input_weight !== w0) begin
        failures++;
        $display("FAIL hold_stable cycle=%0d got=%b/%h want=1/%h", i, out_valid, input_weight, w0);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, spike_ready} !== 2'b00) begin
      failures++; $display("FAIL hold_release got=%b want=00", {out_valid, spike_ready});
    end
  endtask

  task automatic test_toggle_drop();
    exp_t got, e; bit ok;
    logic [3:0] seen, want;
    want = 4'b1010;
    start_ts();
    spike_valid = 1'b1; spike_src = 4'd0;
    for (int i = 3; i >= 0; i--) begin
      seen[i] = spike_ready;
      tick();
    end
    checks++;
    if (seen !== want) begin failures++; $display("FAIL ready_toggle got=%b want=%b", seen, want); end
    spike_src = 4'd12;
    tick();
    tick();
    spike_valid = 1'b0;
    tick();
    checks++;
    if ({drop_flag, spike_count} !== {1'b1, 8'd2}) begin
      failures++; $display("FAIL drop_state got=%b/%0d want=1/2", drop_flag, spike_count);
    end
    exp_q.push_back('{w: 32'h4000_0000, cnt: 8'd2, drop: 1'b1});
    finish_ts(got, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin failures++; $display("FAIL drop_result got=%h ok=%b want=%h", got, ok, e); end
  endtask

  task automatic test_write_collision();
    exp_t got, e; bit ok;
    start_ts();
    spike_valid = 1'b1; spike_src = 4'd0;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h4080_0000;
    tick();
    spike_valid = 1'b0; wr_en = 1'b0;
    send_spike(4'd0);
    exp_q.push_back('{w: 32'h40A0_0000, cnt: 8'd2, drop: 1'b0});
    finish_ts(got, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin failures++; $display("FAIL collision_result got=%h ok=%b want=%h", got, ok, e); end
  endtask

  task automatic test_coincident_end();
    exp_t got, e;
    write_w(4'd0, 32'h3F00_0000);
    start_ts();
    spike_valid = 1'b1; spike_src = 4'd0; ts_end = 1'b1;
    exp_q.push_back('{w: 32'h3F00_0000, cnt: 8'd1, drop: 1'b0});
    tick();
    spike_valid = 1'b0; ts_end = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL coinc_early got=%b want=0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL coinc_latency got=%b want=1", out_valid); end
    got = '{w: input_weight, cnt: spike_count, drop: drop_flag};
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL coinc_result got=%h want=%h", got, e); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_saturate();
    exp_t got, e; bit ok;
    write_w(4'd0, 32'h3F80_0000);
    start_ts();
    for (int i = 0; i < 256; i++) send_spike(4'd0);
    exp_q.push_back('{w: 32'h4380_0000, cnt: 8'hFF, drop: 1'b0});
    finish_ts(got, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin failures++; $display("FAIL saturate_result got=%h ok=%b want=%h", got, ok, e); end
  endtask

  task automatic test_reset_mid();
    exp_t got, e; bit ok;
    start_ts();
    spike_valid = 1'b1; spike_src = 4'd0;
    tick();
    spike_valid = 1'b0;
    #2;
    RST_N_Accum = 1'b0;
    #1;
    checks++;
    if ({out_valid, spike_ready, input_weight, spike_count, drop_flag, exc_flag} !== 44'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h want=0",
               {out_valid, spike_ready, input_weight, spike_count, drop_flag, exc_flag});
    end
    tick();
    tick();
    RST_N_Accum = 1'b1;
    tick();
    start_ts();
    send_spike(4'd0);
    exp_q.push_back('{w: 32'h0000_0000, cnt: 8'd1, drop: 1'b0});
    finish_ts(got, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin failures++; $display("FAIL reset_weights got=%h ok=%b want=%h", got, ok, e); end
  endtask

  initial begin
    RST_N_Accum = 1'b0;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'd0;
    ts_start = 1'b0; ts_end = 1'b0;
    spike_valid = 1'b0; spike_src = 4'd0; out_ready = 1'b0;
    tick();
    tick();
    test_reset();
    RST_N_Accum = 1'b1;
    tick();
    test_sum();
    test_empty_hold();
    test_toggle_drop();
    test_write_collision();
    test_coincident_end();
    test_saturate();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
